// File: rtl/sd_result_checker.sv
// Checks a stream of redundant radix-2 adder results against expected two's-complement values.
// Three-stage pipeline (convert, combine, compare) under a small run-control FSM.
module sd_result_checker #(
    parameter  int DIGITS     = 15,
    parameter  int ADDR_WIDTH = 11,
    localparam int SUM_W      = 2 * (DIGITS + 1),
    localparam int VAL_W      = DIGITS + 2
) (
    input  logic                  pll_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vec_count,
    input  logic                  in_valid,
    input  logic [SUM_W-1:0]      sum_in,
    input  logic [VAL_W-1:0]      exp_in,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_idx,
    output logic                  err_seen,
    output logic                  bad_digit
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  accept;

    logic [DIGITS:0]       pos_c, neg_c;
    logic                  bad_c;

    logic                  s1_v, s1_bad;
    logic [DIGITS:0]       s1_pos, s1_neg;
    logic [VAL_W-1:0]      s1_exp;
    logic [ADDR_WIDTH-1:0] s1_tag;

    logic                  s2_v, s2_bad;
    logic [VAL_W-1:0]      s2_val, s2_exp;
    logic [ADDR_WIDTH-1:0] s2_tag;

    assign accept = (state == ST_RUN) && in_valid;
    assign busy   = (state == ST_RUN) || (state == ST_DRAIN);
    assign done   = (state == ST_DONE);

    // Split the signed-digit vector into positive and negative magnitude masks; 2'b10 counts as 0.
    always_comb begin
        pos_c = '0;
        neg_c = '0;
        bad_c = 1'b0;
        for (int unsigned i = 0; i < unsigned'(DIGITS + 1); i++) begin
            case (sum_in[2*i +: 2])
                2'b01:   pos_c[i] = 1'b1;
                2'b11:   neg_c[i] = 1'b1;
                2'b10:   bad_c    = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge pll_clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            idx           <= '0;
            s1_v          <= 1'b0;
            s1_bad        <= 1'b0;
            s1_pos        <= '0;
            s1_neg        <= '0;
            s1_exp        <= '0;
            s1_tag        <= '0;
            s2_v          <= 1'b0;
            s2_bad        <= 1'b0;
            s2_val        <= '0;
            s2_exp        <= '0;
            s2_tag        <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            err_seen      <= 1'b0;
            bad_digit     <= 1'b0;
        end else begin
            s1_v   <= accept;
            s1_bad <= bad_c;
            s1_pos <= pos_c;
            s1_neg <= neg_c;
            s1_exp <= exp_in;
            s1_tag <= idx;

            s2_v   <= s1_v;
            s2_bad <= s1_bad;
            s2_val <= {1'b0, s1_pos} - {1'b0, s1_neg};
            s2_exp <= s1_exp;
            s2_tag <= s1_tag;

            if (s2_v) begin
                if (s2_bad)
                    bad_digit <= 1'b1;
                if (s2_val != s2_exp) begin
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                    if (!err_seen) begin
                        err_seen      <= 1'b1;
                        first_err_idx <= s2_tag;
                    end
                end
            end

            // The result clear on start is placed after the stage-3 update so it takes priority.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cnt           <= vec_count;
                        idx           <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        err_seen      <= 1'b0;
                        bad_digit     <= 1'b0;
                        state         <= (vec_count == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        idx <= idx + ADDR_WIDTH'(1);
                        if (idx == cnt - ADDR_WIDTH'(1))
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_v && !s2_v)
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sd_result_checker.md
SD_RESULT_CHECKER -- requirements
Module: sd_result_checker

Interface
REQ-001 Parameter DIGITS, default 15: input digit count of the radix-2 adder operands.
REQ-002 Parameter ADDR_WIDTH, default 11: width of the vector index and count.
REQ-003 Derived constants: SUM_W = 2*(DIGITS+1), the adder output width, with a 2-bit digit per position. VAL_W = DIGITS+2, the two's-complement value width.
REQ-004 pll_clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a check run.
REQ-007 vec_count  input  ADDR_WIDTH  number of vectors in the run; sampled on an accepted start.
REQ-008 in_valid  input  1  sum_in and exp_in are valid this cycle.
REQ-009 sum_in  input  SUM_W  redundant adder result. Digit i occupies bits [2i+1:2i].
REQ-010 exp_in  input  VAL_W  expected result as two's complement.
REQ-011 busy  output  1  run in progress (RUN or DRAIN).
REQ-012 done  output  1  held high in DONE until the next accepted start or reset.
REQ-013 err_count  output  16  number of mismatching vectors; saturates.
REQ-014 first_err_idx  output  ADDR_WIDTH  index of the first mismatching vector.
REQ-015 err_seen  output  1  at least one mismatch in this run.
REQ-016 bad_digit  output  1  sticky flag: a 2'b10 digit code was received in this run.

Function
REQ-017 Digit codes: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = illegal. An illegal digit is treated as 0 and sets bad_digit.
REQ-018 Conversion: P = sum of 2^i over digits that are +1; N = sum of 2^i over digits that are -1. value = P - N, computed in VAL_W bits, two's complement.
REQ-019 Pipeline: S1 registers P, N, the bad flag and exp_in. S2 registers value and exp. S3 compares and updates the counters.
REQ-020 Latency: an input accepted at cycle t updates the outputs visible at cycle t+3.
REQ-021 States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
REQ-022 IDLE or DONE, start=1: latch vec_count, clear all result outputs and the index counter, go to RUN. If vec_count = 0, go directly to DONE with all results 0.
REQ-023 RUN: in_valid=1 accepts a vector tagged with the current index; the index then increments. After accepting vector vec_count-1, go to DRAIN.
REQ-024 in_valid is ignored in IDLE, DRAIN and DONE.
REQ-025 start is ignored in RUN and DRAIN.
REQ-026 DRAIN: wait until no valid entries remain in S1-S3, then go to DONE. The pipeline never stalls.
REQ-027 Mismatch: value != exp.
- Increment err_count, saturating at 16'hFFFF.
- On the first mismatch of the run, set err_seen and capture the vector's tag into first_err_idx.
- first_err_idx = 0 while err_seen = 0.
REQ-028 Index wrap: vec_count = 2^ADDR_WIDTH-1 is the maximum run length. The index never wraps within a run.
REQ-029 Simultaneous start and in_valid in IDLE: start is taken; that in_valid is not accepted.
REQ-030 done = 1 exactly in DONE; busy = 1 exactly in RUN and DRAIN.

Reset
REQ-031 reset=1 in any state, including mid-run: the next state is IDLE. Pipeline valid bits are cleared.
REQ-032 Reset values: busy=0, done=0, err_count=0, first_err_idx=0, err_seen=0, bad_digit=0.
REQ-033 Vectors in flight at reset are discarded and never counted.

Verification
REQ-034 start, vec_count=4; four in_valid cycles.
- Sums: digits all 0; d0=+1; d1=+1,d0=-1; d15=-1.
- Expected: 0, 1, 1, -32768 (VAL_W=17).
- Required: done with err_count=0, err_seen=0.
REQ-035 start, vec_count=3; vector 1 has exp_in off by 1.
- Required: err_count=1, first_err_idx=1, err_seen=1.
- done asserted 3 cycles after the last accept plus the DRAIN exit.
REQ-036 start, vec_count=0.
- Required: done=1 on the next cycle, busy never 1, all counts 0.
REQ-037 Vector containing a 2'b10 digit with exp_in computed treating it as 0.
- Required: bad_digit=1, err_count=0.
REQ-038 reset asserted mid-run after 2 of 5 vectors, then start, vec_count=1, with a matching vector.
- Required: err_count=0, done=1.
- Pre-reset vectors are not counted.
REQ-039 start pulsed during RUN, and in_valid during DRAIN and DONE.
- Required: no effect on vec_count, the index or the counters.
